// File: rtl/mac_tree_pkg.sv
// mac_tree_pkg
// Shared helpers for the multiply-accumulate tree bank: elaboration-time
// width functions and the request tag that travels down the pipeline
// alongside the partial sums.
package mac_tree_pkg;

    // Channel field of the tag is fixed-width so the struct can live in the
    // package; the bank uses the low CW bits, which limits CHANNELS to 256.
    localparam int TAG_CHAN_W = 8;

    typedef struct packed {
        logic [TAG_CHAN_W-1:0] chan;
        logic                  acc;
    } tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Select width for channel ports; a single-channel bank still gets one bit.
    function automatic int chan_w(input int channels);
        return max2(1, clog2(channels));
    endfunction

    // Full-precision width of adder-tree level k (level 0 = raw products).
    function automatic int level_w(input int w_in, input int k);
        return 2 * w_in + k;
    endfunction

    function automatic logic [63:0] width_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree
// Registered pairwise adder tree reducing LANES products to one sum in
// clog2(LANES) cycles. Each level keeps full precision (level k is
// 2*W_IN+k bits wide); a valid bit and request tag ride alongside.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears valids only)
//   in_valid   products on in_prod belong to a live request
//   in_tag     request tag accompanying in_prod
//   in_prod    LANES packed products, lane 0 in the low bits
//   out_valid  out_sum/out_tag hold a finished reduction
//   out_tag    tag of the finished reduction
//   out_sum    sum of all LANES products
//   busy       any tree level holds a live request
module mac_adder_tree
    import mac_tree_pkg::*;
#(
    parameter int LANES = 8,
    parameter int W_IN  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  tag_t                                in_tag,
    input  logic [LANES*2*W_IN-1:0]             in_prod,
    output logic                                out_valid,
    output tag_t                                out_tag,
    output logic [2*W_IN+clog2(LANES)-1:0]      out_sum,
    output logic                                busy
);

    localparam int LW = clog2(LANES);
    localparam int PW = 2 * W_IN;
    localparam int SW = PW + LW;

    // lvl[k-1][i] holds node i of tree level k; only the first LANES>>k
    // entries of each level are live.
    logic [SW-1:0] lvl [LW][LANES];
    logic [LW-1:0] v;
    tag_t          t   [LW];

    // Masking each level to its natural width lets synthesis drop the
    // always-zero upper bits of the shallow levels.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES / 2; i++) begin
            lvl[0][i] <= (SW'(in_prod[2*i*PW +: PW]) + SW'(in_prod[(2*i+1)*PW +: PW]))
                         & SW'(width_mask(level_w(W_IN, 1)));
        end
        for (int k = 2; k <= LW; k++) begin
            for (int i = 0; i < LANES / 2; i++) begin
                if (i < (LANES >> k)) begin
                    lvl[k-1][i] <= (lvl[k-2][2*i] + lvl[k-2][2*i+1])
                                   & SW'(width_mask(level_w(W_IN, k)));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            v[0] <= in_valid;
            for (int k = 1; k < LW; k++) begin
                v[k] <= v[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        t[0] <= in_tag;
        for (int k = 1; k < LW; k++) begin
            t[k] <= t[k-1];
        end
    end

    assign out_valid = v[LW-1];
    assign out_tag   = t[LW-1];
    assign out_sum   = lvl[LW-1][0];
    assign busy      = |v;

endmodule

// File: rtl/mac_tree_bank.sv
// mac_tree_bank
// CHANNELS banks of LANES unsigned operand pairs. A start request latches
// the channel's products, reduces them through a pipelined adder tree and
// either overwrites or accumulates into the channel's result register,
// with optional saturation and a sticky per-channel overflow flag.
// Accepts one request per cycle; done follows start by LW+2 cycles.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr_data      operand write value
//   wr_a, wr_b   write wr_data into A / B at [wr_chan][wr_lane]
//   wr_chan      write channel (out-of-range writes ignored)
//   wr_lane      write lane
//   start        launch a dot product for start_chan
//   start_chan   channel to compute (out-of-range requests dropped)
//   acc_mode     1 = add to stored result, 0 = overwrite
//   rd_chan      result read select
//   rd_data      result[rd_chan], combinational; 0 when out of range
//   ovf          per-channel sticky overflow
//   done         one-cycle pulse when a result register was updated
//   done_chan    channel updated while done=1, else 0
//   busy         any pipeline stage holds a live request
module mac_tree_bank
    import mac_tree_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int LANES    = 8,
    parameter int W_IN     = 3,
    parameter int W_OUT    = 8,
    parameter int SAT      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [W_IN-1:0]               wr_data,
    input  logic                          wr_a,
    input  logic                          wr_b,
    input  logic [chan_w(CHANNELS)-1:0]   wr_chan,
    input  logic [clog2(LANES)-1:0]       wr_lane,
    input  logic                          start,
    input  logic [chan_w(CHANNELS)-1:0]   start_chan,
    input  logic                          acc_mode,
    input  logic [chan_w(CHANNELS)-1:0]   rd_chan,
    output logic [W_OUT-1:0]              rd_data,
    output logic [CHANNELS-1:0]           ovf,
    output logic                          done,
    output logic [chan_w(CHANNELS)-1:0]   done_chan,
    output logic                          busy
);

    localparam int CW = chan_w(CHANNELS);
    localparam int LW = clog2(LANES);
    localparam int PW = 2 * W_IN;
    localparam int TW = PW + LW;
    localparam int FW = max2(W_OUT, TW) + 1;

    logic [W_IN-1:0]    op_a   [CHANNELS][LANES];
    logic [W_IN-1:0]    op_b   [CHANNELS][LANES];
    logic [W_OUT-1:0]   result [CHANNELS];

    logic               st_valid;
    tag_t               st_tag;
    logic [LANES*PW-1:0] st_prod;
    logic               start_ok;

    logic               tree_valid;
    tag_t               tree_tag;
    logic [TW-1:0]      tree_sum;
    logic               tree_busy;

    logic [CW-1:0]      fin_ch;
    logic [W_OUT-1:0]   fin_base;
    logic [FW-1:0]      fin_sum;
    logic               fin_over;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int l = 0; l < LANES; l++) begin
                    op_a[c][l] <= '0;
                    op_b[c][l] <= '0;
                end
            end
        end else if (int'(wr_chan) < CHANNELS) begin
            if (wr_a) begin
                op_a[wr_chan][wr_lane] <= wr_data;
            end
            if (wr_b) begin
                op_b[wr_chan][wr_lane] <= wr_data;
            end
        end
    end

    assign start_ok = start && (int'(start_chan) < CHANNELS);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= 1'b0;
        end else begin
            st_valid <= start_ok;
        end
    end

    // Operands are read from their registers, so a write landing on the
    // same edge as start is not seen by this request.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            st_tag.chan <= TAG_CHAN_W'(start_chan);
            st_tag.acc  <= acc_mode;
            for (int l = 0; l < LANES; l++) begin
                st_prod[l*PW +: PW] <= PW'(op_a[start_chan][l]) * PW'(op_b[start_chan][l]);
            end
        end
    end

    mac_adder_tree #(
        .LANES (LANES),
        .W_IN  (W_IN)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (st_valid),
        .in_tag    (st_tag),
        .in_prod   (st_prod),
        .out_valid (tree_valid),
        .out_tag   (tree_tag),
        .out_sum   (tree_sum),
        .busy      (tree_busy)
    );

    // Reading the live result register lets back-to-back accumulates on one
    // channel chain without forwarding: the previous update has already
    // landed by the time the next request reaches this stage.
    always_comb begin
        fin_ch   = tree_tag.chan[CW-1:0];
        fin_base = '0;
        if (tree_tag.acc) begin
            fin_base = result[fin_ch];
        end
        fin_sum  = FW'(fin_base) + FW'(tree_sum);
        fin_over = fin_sum > FW'({W_OUT{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                result[c] <= '0;
            end
            ovf       <= '0;
            done      <= 1'b0;
            done_chan <= '0;
        end else begin
            done      <= tree_valid;
            done_chan <= tree_valid ? fin_ch : '0;
            if (tree_valid) begin
                result[fin_ch] <= (fin_over && (SAT != 0)) ? {W_OUT{1'b1}} : fin_sum[W_OUT-1:0];
                // Overwrite restarts the sticky flag; accumulate keeps it.
                ovf[fin_ch]    <= fin_over | (tree_tag.acc & ovf[fin_ch]);
            end
        end
    end

    assign rd_data = (int'(rd_chan) < CHANNELS) ? result[rd_chan] : '0;
    assign busy    = st_valid | tree_busy;

    generate
        if (CW < TAG_CHAN_W) begin : g_tag_hi
            logic unused_tag_hi;
            assign unused_tag_hi = ^tree_tag.chan[TAG_CHAN_W-1:CW];
        end
    endgenerate

endmodule
